// File: rtl/seg_scan_display.sv
// seg_scan_display: time-multiplexed common-anode 7-segment hex scan driver.
// Takes a per-frame snapshot of data/dp/blank/bright, applies PWM brightness
// within each digit slot, and keeps the last cycle of every slot dark so
// neighbouring digits cannot ghost into each other.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module seg_scan_display #(
  parameter int unsigned DIGITS      = 8,
  parameter int unsigned SLOT_CYCLES = 6,
  parameter int unsigned BRIGHT_W    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   data_to_show,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blank,
  input  logic [BRIGHT_W-1:0]   bright,
  output logic [7:0]            SEG,
  output logic [DIGITS-1:0]     AN,
  output logic                  frame_start
);

  localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned PW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  // Wide enough for (2^BRIGHT_W) * SLOT_CYCLES without overflow.
  localparam int unsigned MW = CW + BRIGHT_W + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
  localparam logic [PW-1:0] POS_LAST = PW'(DIGITS - 1);

  logic [CW-1:0]         cnt, p_cnt;
  logic [PW-1:0]         pos, p_pos;
  logic [4*DIGITS-1:0]   data_s;
  logic [DIGITS-1:0]     dp_s, blank_s, blank_in;
  logic [BRIGHT_W-1:0]   bright_s;
  logic                  snap;
  logic                  lit;
  logic [MW-1:0]         pwm_lhs, pwm_rhs;
  logic [3:0]            nib;
  logic [6:0]            font;
  logic [DIGITS-1:0]     an_d;
  logic [7:0]            seg_d;

  // Snapshot point: first cycle of digit 0.
  always_comb snap = (cnt == '0) && (pos == '0);

`ifdef LEADING_ZERO_BLANK_EN
  logic [PW-1:0] keep_top;

  // Highest digit that must stay visible: top nonzero nibble or top dp, never below 0.
  always_comb begin
    keep_top = '0;
    for (int i = 1; i < DIGITS; i++) begin
      if (data_to_show[4*i +: 4] != 4'h0 || dp[i]) keep_top = PW'(i);
    end
    blank_in = blank;
    for (int i = 1; i < DIGITS; i++) begin
      if (PW'(i) > keep_top) blank_in[i] = 1'b1;
    end
  end
`else
  // No suppression: only the blank input darkens digits.
  always_comb blank_in = blank;
`endif

  // Slot state is delayed one cycle so each frame's slots all see that frame's snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      pos         <= '0;
      p_cnt       <= CNT_LAST;
      p_pos       <= '0;
      data_s      <= '0;
      dp_s        <= '0;
      blank_s     <= '0;
      bright_s    <= '0;
      AN          <= '1;
      SEG         <= 8'hFF;
      frame_start <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        pos <= (pos == POS_LAST) ? '0 : pos + PW'(1);
      end else begin
        cnt <= cnt + CW'(1);
      end
      p_cnt <= cnt;
      p_pos <= pos;
      if (snap) begin
        data_s   <= data_to_show;
        dp_s     <= dp;
        blank_s  <= blank_in;
        bright_s <= bright;
      end
      frame_start <= snap;
      AN          <= an_d;
      SEG         <= seg_d;
    end
  end

  // Lit decision: not the dead cycle, within PWM duty, digit not blanked.
  always_comb begin
    pwm_lhs = MW'(p_cnt) << BRIGHT_W;
    pwm_rhs = (MW'(bright_s) + MW'(1)) * MW'(SLOT_CYCLES);
    lit     = (p_cnt != CNT_LAST) && (pwm_lhs < pwm_rhs) && !blank_s[p_pos];
  end

  // Active-low hex font, segments g..a.
  always_comb begin
    nib = data_s[{p_pos, 2'b00} +: 4];
    unique case (nib)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h18;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      4'hF: font = 7'h0E;
      default: font = 7'h7F;
    endcase
  end

  // Next-cycle pin values; everything dark when not lit.
  always_comb begin
    an_d  = '1;
    seg_d = 8'hFF;
    if (lit) begin
      an_d  = ~(DIGITS'(1) << p_pos);
      seg_d = {~dp_s[p_pos], font};
    end
  end

endmodule
